// File: rtl/hub75_row_driver.sv
// HUB75 panel scan driver: pulls packed 36-bit words (six 6-bit columns) from the
// image memory stage, shifts them out on o_rgb/o_sclk, then latches and lights each row pair.
module hub75_row_driver #(
   parameter int  COLS      = 60,
   parameter int  ROW_PAIRS = 16,
   parameter int  CLK_DIV   = 4,
   parameter int  ON_TIME   = 256,
   localparam int RW        = $clog2(ROW_PAIRS)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_en,
   output logic          o_request,
   input  logic [35:0]   i_valor,
   output logic [5:0]    o_rgb,
   output logic          o_sclk,
   output logic          o_lat,
   output logic          o_oe_n,
   output logic [RW-1:0] o_row,
   output logic          o_frame_done
);

   localparam int WPR = COLS / 6;
   localparam int WW  = (WPR > 1) ? $clog2(WPR) : 1;
   localparam int PW  = $clog2(CLK_DIV);
   localparam int DW  = $clog2(ON_TIME + 1);

   localparam logic [WW-1:0] WORD_LAST = WW'(WPR - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(ROW_PAIRS - 1);
   localparam logic [PW-1:0] PH_LAST   = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PH_HALF   = PW'(CLK_DIV / 2);
   localparam logic [DW-1:0] DISP_LAST = DW'(ON_TIME - 1);
   localparam logic [2:0]    COL_LAST  = 3'd5;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      SHIFT,
      BLANK,
      LATCH,
      DISPLAY
   } state_e;

   state_e        state_q;
   logic          request_q;
   logic [5:0]    rgb_q;
   logic          sclk_q;
   logic          lat_q;
   logic          oe_n_q;
   logic [RW-1:0] row_q;
   logic          frame_done_q;
   logic [RW-1:0] row_cnt_q;
   logic [WW-1:0] word_cnt_q;
   logic [2:0]    col_q;
   logic [PW-1:0] ph_q;
   logic [DW-1:0] disp_q;
   logic [35:0]   word_q;

   // Outputs are registered alongside the state: each is set on the transition
   // into the state that owns it, so it is valid for exactly that state's cycles.
   // word_q is a left-shifting column queue; its top 6 bits are always the next column.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         request_q    <= 1'b0;
         rgb_q        <= '0;
         sclk_q       <= 1'b0;
         lat_q        <= 1'b0;
         oe_n_q       <= 1'b1;
         row_q        <= '0;
         frame_done_q <= 1'b0;
         row_cnt_q    <= '0;
         word_cnt_q   <= '0;
         col_q        <= '0;
         ph_q         <= '0;
         disp_q       <= '0;
         word_q       <= '0;
      end else begin
         request_q    <= 1'b0;
         lat_q        <= 1'b0;
         frame_done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (i_en) begin
                  state_q   <= FETCH;
                  request_q <= 1'b1;
               end
            end
            FETCH: state_q <= WAIT;
            WAIT: begin
               state_q <= SHIFT;
               rgb_q   <= i_valor[35:30];
               word_q  <= {i_valor[29:0], 6'b0};
               col_q   <= '0;
               ph_q    <= '0;
               sclk_q  <= 1'b0;
            end
            SHIFT: begin
               if (ph_q != PH_LAST) begin
                  ph_q   <= ph_q + 1'b1;
                  sclk_q <= (ph_q + 1'b1) >= PH_HALF;
               end else if (col_q != COL_LAST) begin
                  col_q  <= col_q + 1'b1;
                  ph_q   <= '0;
                  sclk_q <= 1'b0;
                  rgb_q  <= word_q[35:30];
                  word_q <= {word_q[29:0], 6'b0};
               end else begin
                  sclk_q <= 1'b0;
                  if (word_cnt_q != WORD_LAST) begin
                     word_cnt_q <= word_cnt_q + 1'b1;
                     state_q    <= FETCH;
                     request_q  <= 1'b1;
                  end else begin
                     state_q <= BLANK;
                     row_q   <= row_cnt_q;
                  end
               end
            end
            BLANK: begin
               state_q <= LATCH;
               lat_q   <= 1'b1;
            end
            LATCH: begin
               state_q <= DISPLAY;
               oe_n_q  <= 1'b0;
               disp_q  <= '0;
            end
            DISPLAY: begin
               if (disp_q != DISP_LAST) begin
                  disp_q <= disp_q + 1'b1;
               end else begin
                  oe_n_q     <= 1'b1;
                  word_cnt_q <= '0;
                  if (row_cnt_q != ROW_LAST) begin
                     row_cnt_q <= row_cnt_q + 1'b1;
                     state_q   <= FETCH;
                     request_q <= 1'b1;
                  end else begin
                     row_cnt_q    <= '0;
                     frame_done_q <= 1'b1;
                     state_q      <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_request    = request_q;
   assign o_rgb        = rgb_q;
   assign o_sclk       = sclk_q;
   assign o_lat        = lat_q;
   assign o_oe_n       = oe_n_q;
   assign o_row        = row_q;
   assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_row_driver.sv
// Directed bench for hub75_row_driver (60 columns, 16 row pairs, CLK_DIV 4, ON_TIME 256)
// with a behavioural memory stage and a negedge monitor that tallies panel activity.
module tb_hub75_row_driver;

   localparam int FRAME_WORDS = 160;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        memRst;
   logic        o_request;
   logic [35:0] valor = '0;
   logic [5:0]  o_rgb;
   logic        o_sclk;
   logic        o_lat;
   logic        o_oe_n;
   logic [3:0]  o_row;
   logic        o_frame_done;

   logic [35:0] mem [FRAME_WORDS];
   int          memAddr = 0;

   int checks = 0;
   int errors = 0;

   int cyc = 0, reqTotal = 0, riseTotal = 0, latTotal = 0, fdTotal = 0, oeRuns = 0;
   int rgbErr = 0, rowErr = 0, overlap = 0, reqClose = 0, oeRunBad = 0, oeLowTotal = 0;
   int lastOeRun = 0, oeRun = 0, lastSclkCyc = 0, latGap = 0, riseInWord = 0;
   logic [3:0]  lastLatRow = '0;
   logic [3:0]  rowExp = '0;
   logic [35:0] expWord = '0;
   logic        prevSclk = 1'b0, req1 = 1'b0, req2 = 1'b0;

   hub75_row_driver #(
      .COLS(60), .ROW_PAIRS(16), .CLK_DIV(4), .ON_TIME(256)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_en(en),
      .o_request(o_request),
      .i_valor(valor),
      .o_rgb(o_rgb),
      .o_sclk(o_sclk),
      .o_lat(o_lat),
      .o_oe_n(o_oe_n),
      .o_row(o_row),
      .o_frame_done(o_frame_done)
   );

   always #5 clk = ~clk;

   // Word 0 puts all-ones in the first column only; the rest carry distinct column values.
   initial begin
      for (int i = 0; i < FRAME_WORDS; i++) begin
         if (i == 0) mem[i] = 36'hFC0000000;
         else mem[i] = {6'(i), 6'(i + 7), 6'(i + 14), 6'(i + 21), 6'(i + 28), 6'(i + 35)} ^ 36'hA5A5A5A5A;
      end
   end

   // Memory stage: word appears the cycle after a request, address wraps per frame.
   always @(posedge clk) begin
      if (memRst) memAddr <= 0;
      else if (o_request) begin
         valor   <= mem[memAddr];
         memAddr <= (memAddr + 1) % FRAME_WORDS;
      end
   end

   // Monitor tallies requests, shift edges, latches and display runs, and checks
   // each shifted column against the word the memory stage was asked for.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         rowExp = '0; oeRun = 0; riseInWord = 0; prevSclk = 1'b0; req1 = 1'b0; req2 = 1'b0;
      end else begin
         if (o_request) begin
            reqTotal++;
            if (req1 || req2) reqClose++;
            expWord    = mem[memAddr];
            riseInWord = 0;
         end
         req2 = req1;
         req1 = o_request;
         if (o_sclk && !prevSclk) begin
            riseTotal++;
            if (riseInWord > 5) rgbErr++;
            else if (o_rgb !== 6'((expWord >> (30 - 6 * riseInWord)) & 36'h3F)) rgbErr++;
            riseInWord++;
         end
         if (o_sclk) lastSclkCyc = cyc;
         prevSclk = o_sclk;
         if (o_lat) begin
            latTotal++;
            latGap     = cyc - lastSclkCyc;
            lastLatRow = o_row;
            if (o_row !== rowExp) rowErr++;
            rowExp = rowExp + 4'd1;
            if (!o_oe_n) overlap++;
         end
         if (!o_oe_n) begin
            oeRun++;
            oeLowTotal++;
         end else if (oeRun != 0) begin
            lastOeRun = oeRun;
            oeRuns++;
            if (oeRun != 256) oeRunBad++;
            oeRun = 0;
         end
         if (o_frame_done) fdTotal++;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rstN, input logic enable);
      rst_n  = rstN;
      memRst = ~rstN;
      en     = enable;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic int counterOf(input int which);
      case (which)
         0:       return reqTotal;
         1:       return riseTotal;
         2:       return latTotal;
         3:       return fdTotal;
         default: return oeRuns;
      endcase
   endfunction

   task automatic waitCount(input int which, input int target, input int limit, input string tag);
      int n = 0;
      while (counterOf(which) < target && n < limit) begin
         step();
         n++;
      end
      checkOutput(tag, counterOf(which), target);
   endtask

   int resetReqs = 0;
   int baseReq, baseRise, baseLat, baseFd, baseRuns, baseOe, f2Req, r;
   int gotReq;

   initial begin
      applyStimulus(1'b0, 1'b1);
      repeat (6) begin
         step();
         if (o_request !== 1'b0) resetReqs++;
      end
      checkOutput("reset_requests", resetReqs, 0);
      checkOutput("reset_rgb", o_rgb, 6'h00);
      checkOutput("reset_sclk", o_sclk, 1'b0);
      checkOutput("reset_lat", o_lat, 1'b0);
      checkOutput("reset_oe_n", o_oe_n, 1'b1);
      checkOutput("reset_row", o_row, 4'd0);
      checkOutput("reset_frame_done", o_frame_done, 1'b0);

      // First word: all-ones column then five zero columns
      @(negedge clk);
      applyStimulus(1'b1, 1'b1);
      baseReq = reqTotal; baseRise = riseTotal; baseLat = latTotal; baseFd = fdTotal; baseRuns = oeRuns;
      waitCount(0, baseReq + 1, 10, "first_request");
      waitCount(1, baseRise + 1, 40, "first_rise");
      checkOutput("rise1_rgb", o_rgb, 6'h3F);
      for (int k = 2; k <= 6; k++) begin
         waitCount(1, baseRise + k, 20, "next_rise");
         checkOutput("rise_zero_rgb", o_rgb, 6'h00);
      end
      checkOutput("word0_requests", reqTotal - baseReq, 1);

      // First row pair: 10 words, 60 columns, blank, latch, display
      waitCount(2, baseLat + 1, 2000, "first_latch");
      checkOutput("row0_requests", reqTotal - baseReq, 10);
      checkOutput("row0_rises", riseTotal - baseRise, 60);
      checkOutput("blank_gap", latGap, 2);
      checkOutput("row0_addr", lastLatRow, 4'd0);
      waitCount(4, baseRuns + 1, 400, "first_display");
      checkOutput("row0_on_time", lastOeRun, 256);

      // Whole frame
      waitCount(3, baseFd + 1, 10000, "frame_done");
      checkOutput("frame_requests", reqTotal - baseReq, 160);
      checkOutput("frame_rises", riseTotal - baseRise, 960);
      checkOutput("frame_latches", latTotal - baseLat, 16);
      checkOutput("frame_displays", oeRuns - baseRuns, 16);
      checkOutput("last_row_addr", lastLatRow, 4'd15);
      f2Req = reqTotal;
      step();
      checkOutput("frame_done_width", o_frame_done, 1'b0);
      r = latTotal;
      waitCount(2, r + 1, 2000, "frame2_latch");
      checkOutput("frame2_row_addr", lastLatRow, 4'd0);
      checkOutput("frame_done_count", fdTotal - baseFd, 1);

      // Reset while shifting word 3 of the second row pair
      waitCount(0, f2Req + 14, 2000, "word3_request");
      r = riseTotal;
      waitCount(1, r + 1, 20, "word3_rise");
      applyStimulus(1'b0, 1'b1);
      #1;
      checkOutput("midreset_sclk", o_sclk, 1'b0);
      checkOutput("midreset_rgb", o_rgb, 6'h00);
      checkOutput("midreset_request", o_request, 1'b0);
      checkOutput("midreset_oe_n", o_oe_n, 1'b1);
      repeat (3) step();
      applyStimulus(1'b1, 1'b1);
      baseReq = reqTotal; baseLat = latTotal;
      step();
      checkOutput("restart_fetch", o_request, 1'b1);
      waitCount(2, baseLat + 1, 2000, "restart_latch");
      checkOutput("restart_row_addr", lastLatRow, 4'd0);
      checkOutput("restart_requests", reqTotal - baseReq, 10);

      // Idle with enable low after a frame, then resume
      r = fdTotal;
      waitCount(3, r + 1, 10000, "frame_done_2");
      applyStimulus(1'b1, 1'b0);
      baseReq = reqTotal; baseOe = oeLowTotal;
      repeat (1000) step();
      checkOutput("idle_requests", reqTotal - baseReq, 0);
      checkOutput("idle_oe_low", oeLowTotal - baseOe, 0);
      checkOutput("idle_oe_n", o_oe_n, 1'b1);
      applyStimulus(1'b1, 1'b1);
      gotReq = 0;
      for (int k = 0; k < 2; k++) begin
         step();
         if (o_request === 1'b1) gotReq = 1;
      end
      checkOutput("resume_request", gotReq, 1);

      checkOutput("rgb_columns", rgbErr, 0);
      checkOutput("row_sequence", rowErr, 0);
      checkOutput("lat_oe_overlap", overlap, 0);
      checkOutput("request_spacing", reqClose, 0);
      checkOutput("on_time_runs", oeRunBad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
